load_issue_bank_v2: RTL and testbench

- Parametrised successor of the per-pipeline load issue bank in the LSU issue stage.
- Holds dispatched loads until their base register is woken, then issues the oldest ready entry by ROB age instead of a direction selector.
- Adds per-entry replay state: a counted back-off for fast replays, a TLB-miss park state, exception capture, and an occupancy count.
- Entries are freed only on load-pipeline success, or killed on redirect.

---
 rtl/load_issue_bank_v2.sv | 197 +++++++++++++++++++
 tb/tb_load_issue_bank_v2.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_issue_bank_v2.sv
// rtl/load_issue_bank_v2.sv - LSU load issue bank with age select, replay back-off and TLB park
module load_issue_bank_v2 #(
  parameter int DEPTH         = 8,
  parameter int PREG_WIDTH    = 7,
  parameter int ROB_WIDTH     = 6,
  parameter int WAKEUP_PORTS  = 4,
  parameter int PAYLOAD_WIDTH = 64,
  parameter int REPLAY_DELAY  = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enq_valid,
  output logic                               enq_ready,
  input  logic [PREG_WIDTH-1:0]              enq_rs1,
  input  logic                               enq_rs1v,
  input  logic [ROB_WIDTH:0]                 enq_rob,
  input  logic [PAYLOAD_WIDTH-1:0]           enq_payload,
  input  logic [WAKEUP_PORTS-1:0]            wk_en,
  input  logic [WAKEUP_PORTS*PREG_WIDTH-1:0] wk_rd,
  output logic                               iss_valid,
  input  logic                               iss_ready,
  output logic [$clog2(DEPTH)-1:0]           iss_idx,
  output logic [PREG_WIDTH-1:0]              iss_rs1,
  output logic [ROB_WIDTH:0]                 iss_rob,
  output logic [PAYLOAD_WIDTH-1:0]           iss_payload,
  output logic                               iss_exc,
  input  logic                               rep_valid,
  input  logic [$clog2(DEPTH)-1:0]           rep_idx,
  input  logic [1:0]                         rep_reason,
  input  logic                               tlb_wb_valid,
  input  logic [$clog2(DEPTH)-1:0]           tlb_wb_idx,
  input  logic                               tlb_wb_exc,
  input  logic                               succ_valid,
  input  logic [$clog2(DEPTH)-1:0]           succ_idx,
  input  logic                               redirect,
  input  logic [ROB_WIDTH:0]                 redirect_rob,
  output logic [$clog2(DEPTH):0]             count
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_FREE, S_WAIT, S_READY, S_ISSUED, S_BACKOFF, S_TLBWAIT
  } state_e;

  state_e                   state_q   [DEPTH];
  state_e                   state_d   [DEPTH];
  logic [3:0]               cnt_q     [DEPTH];
  logic [3:0]               cnt_d     [DEPTH];
  logic                     exc_q     [DEPTH];
  logic                     exc_d     [DEPTH];
  logic [PREG_WIDTH-1:0]    rs1_q     [DEPTH];
  logic [ROB_WIDTH:0]       rob_q     [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] payload_q [DEPTH];
  logic [IW:0]              count_q;
  logic [IW:0]              count_d;

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          alloc_found;
  logic [IW-1:0] alloc_idx;
  logic          enq_fire;
  logic          iss_fire;

  // a is older than b, honouring the ROB wrap (dir) bit
  function automatic logic older(input logic [ROB_WIDTH:0] a, input logic [ROB_WIDTH:0] b);
    if (a[ROB_WIDTH] == b[ROB_WIDTH]) return a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0];
    else                              return a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0];
  endfunction

  // register r is broadcast on any enabled wakeup port this cycle
  function automatic logic woken(input logic [PREG_WIDTH-1:0] r,
                                 input logic [WAKEUP_PORTS-1:0] en,
                                 input logic [WAKEUP_PORTS*PREG_WIDTH-1:0] rd);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < WAKEUP_PORTS; j++) begin
      if (en[j] && rd[j*PREG_WIDTH +: PREG_WIDTH] == r) hit = 1'b1;
    end
    return hit;
  endfunction

  // oldest READY entry; strict compare keeps the lower index on an age tie
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (state_q[i] == S_READY && (!sel_found || older(rob_q[i], rob_q[sel_idx]))) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // lowest-index FREE entry for allocation
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == S_FREE) begin
        alloc_found = 1'b1;
        alloc_idx   = IW'(i);
      end
    end
  end

  assign enq_ready   = (count_q != (IW+1)'(DEPTH));
  assign enq_fire    = enq_valid & enq_ready & ~redirect & alloc_found;
  assign iss_valid   = sel_found & ~redirect;
  assign iss_fire    = iss_valid & iss_ready;
  assign iss_idx     = sel_found ? sel_idx : '0;
  assign iss_rs1     = sel_found ? rs1_q[sel_idx] : '0;
  assign iss_rob     = sel_found ? rob_q[sel_idx] : '0;
  assign iss_payload = sel_found ? payload_q[sel_idx] : '0;
  assign iss_exc     = sel_found & exc_q[sel_idx];
  assign count       = count_q;

  // per-entry next state; success outranks redirect, which outranks normal events
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      exc_d[i]   = exc_q[i];
      case (state_q[i])
        S_FREE: begin
          if (enq_fire && alloc_idx == IW'(i)) begin
            state_d[i] = (enq_rs1v || woken(enq_rs1, wk_en, wk_rd)) ? S_READY : S_WAIT;
            exc_d[i]   = 1'b0;
          end
        end
        S_WAIT: begin
          if (woken(rs1_q[i], wk_en, wk_rd)) state_d[i] = S_READY;
        end
        S_READY: begin
          if (iss_fire && sel_idx == IW'(i)) state_d[i] = S_ISSUED;
        end
        S_ISSUED: begin
          if (rep_valid && rep_idx == IW'(i)) begin
            case (rep_reason)
              2'd0: begin
                state_d[i] = S_BACKOFF;
                cnt_d[i]   = 4'(REPLAY_DELAY);
              end
              2'd3:    state_d[i] = S_TLBWAIT;
              default: state_d[i] = S_READY;
            endcase
          end
        end
        S_BACKOFF: begin
          if (cnt_q[i] <= 4'd1) begin
            state_d[i] = S_READY;
            cnt_d[i]   = 4'd0;
          end else begin
            cnt_d[i] = cnt_q[i] - 4'd1;
          end
        end
        S_TLBWAIT: begin
          if (tlb_wb_valid && tlb_wb_idx == IW'(i)) begin
            state_d[i] = S_READY;
            exc_d[i]   = exc_q[i] | tlb_wb_exc;
          end
        end
        default: state_d[i] = S_FREE;
      endcase
      if (redirect && state_q[i] != S_FREE && !older(rob_q[i], redirect_rob)) state_d[i] = S_FREE;
      if (succ_valid && succ_idx == IW'(i)) state_d[i] = S_FREE;
      if (state_d[i] != S_FREE) count_d = count_d + (IW+1)'(1);
    end
  end

  // state registers; entry fields are captured only on allocation
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i]   <= S_FREE;
        cnt_q[i]     <= 4'd0;
        exc_q[i]     <= 1'b0;
        rs1_q[i]     <= '0;
        rob_q[i]     <= '0;
        payload_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        exc_q[i]   <= exc_d[i];
        if (enq_fire && alloc_idx == IW'(i)) begin
          rs1_q[i]     <= enq_rs1;
          rob_q[i]     <= enq_rob;
          payload_q[i] <= enq_payload;
        end
      end
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_load_issue_bank_v2.sv
// tb/tb_load_issue_bank_v2.sv - scoreboard bench for load_issue_bank_v2
module tb_load_issue_bank_v2;
  localparam int DEPTH = 8, PREG_WIDTH = 7, ROB_WIDTH = 6, WAKEUP_PORTS = 4;
  localparam int PAYLOAD_WIDTH = 64, REPLAY_DELAY = 3;

  logic clk = 1'b0;
  logic rst;
  logic enq_valid, enq_ready, enq_rs1v;
  logic [6:0] enq_rs1;
  logic [6:0] enq_rob;
  logic [63:0] enq_payload;
  logic [3:0] wk_en;
  logic [27:0] wk_rd;
  logic iss_valid, iss_ready, iss_exc;
  logic [2:0] iss_idx;
  logic [6:0] iss_rs1;
  logic [6:0] iss_rob;
  logic [63:0] iss_payload;
  logic rep_valid;
  logic [2:0] rep_idx;
  logic [1:0] rep_reason;
  logic tlb_wb_valid, tlb_wb_exc;
  logic [2:0] tlb_wb_idx;
  logic succ_valid;
  logic [2:0] succ_idx;
  logic redirect;
  logic [6:0] redirect_rob;
  logic [3:0] count;

  always #5 clk = ~clk;

  load_issue_bank_v2 #(
    .DEPTH(DEPTH), .PREG_WIDTH(PREG_WIDTH), .ROB_WIDTH(ROB_WIDTH),
    .WAKEUP_PORTS(WAKEUP_PORTS), .PAYLOAD_WIDTH(PAYLOAD_WIDTH), .REPLAY_DELAY(REPLAY_DELAY)
  ) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rs1(enq_rs1), .enq_rs1v(enq_rs1v),
    .enq_rob(enq_rob), .enq_payload(enq_payload),
    .wk_en(wk_en), .wk_rd(wk_rd),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_idx(iss_idx), .iss_rs1(iss_rs1),
    .iss_rob(iss_rob), .iss_payload(iss_payload), .iss_exc(iss_exc),
    .rep_valid(rep_valid), .rep_idx(rep_idx), .rep_reason(rep_reason),
    .tlb_wb_valid(tlb_wb_valid), .tlb_wb_idx(tlb_wb_idx), .tlb_wb_exc(tlb_wb_exc),
    .succ_valid(succ_valid), .succ_idx(succ_idx),
    .redirect(redirect), .redirect_rob(redirect_rob),
    .count(count)
  );

  typedef struct packed {
    logic [6:0] rob;
    logic [2:0] idx;
    logic       exc;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pl(input logic [6:0] r);
    return 64'hA5A5_0000_0000_0000 | 64'(r);
  endfunction

  function automatic exp_t mk(input logic [6:0] r, input logic [2:0] i, input logic e);
    exp_t x;
    x.rob = r; x.idx = i; x.exc = e;
    return x;
  endfunction

  // every issue handshake is matched against the oldest expected issue
  always @(negedge clk) begin
    if (!rst && iss_valid && iss_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_issue", {57'd0, iss_rob}, 64'hFFFF);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_rob", {57'd0, iss_rob}, {57'd0, sb_e.rob});
        chk("sb_idx", {61'd0, iss_idx}, {61'd0, sb_e.idx});
        chk("sb_exc", {63'd0, iss_exc}, {63'd0, sb_e.exc});
        chk("sb_payload", iss_payload, pl(sb_e.rob));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    enq_valid = 0; wk_en = '0; rep_valid = 0; tlb_wb_valid = 0; succ_valid = 0; redirect = 0;
  endtask

  task automatic enq(input logic [6:0] rob, input logic [6:0] rs1, input logic rv);
    enq_valid = 1; enq_rob = rob; enq_rs1 = rs1; enq_rs1v = rv; enq_payload = pl(rob);
    cyc();
  endtask

  initial begin
    rst = 1; enq_valid = 0; enq_rs1 = '0; enq_rs1v = 0; enq_rob = '0; enq_payload = '0;
    wk_en = '0; wk_rd = '0; iss_ready = 0; rep_valid = 0; rep_idx = '0; rep_reason = '0;
    tlb_wb_valid = 0; tlb_wb_idx = '0; tlb_wb_exc = 0; succ_valid = 0; succ_idx = '0;
    redirect = 0; redirect_rob = '0;
    cyc(); cyc();
    rst = 0; #2;
    chk("rst_count", 64'(count), 0);
    chk("rst_enq_ready", 64'(enq_ready), 1);
    chk("rst_iss_valid", 64'(iss_valid), 0);
    chk("rst_iss_exc", 64'(iss_exc), 0);
    chk("rst_iss_rob", 64'(iss_rob), 0);
    chk("rst_iss_payload", iss_payload, 0);

    // fill, then drain in ROB order
    for (int i = 0; i < 8; i++) enq(7'(i), 7'(i), 1'b1);
    #2;
    chk("fill_count", 64'(count), 8);
    chk("fill_enq_ready", 64'(enq_ready), 0);
    chk("fill_iss_rob", 64'(iss_rob), 0);
    for (int i = 0; i < 8; i++) sb_q.push_back(mk(7'(i), 3'(i), 1'b0));
    iss_ready = 1;
    repeat (8) cyc();
    iss_ready = 0; #2;
    chk("drain_iss_valid", 64'(iss_valid), 0);
    chk("drain_count", 64'(count), 8);
    redirect = 1; redirect_rob = 7'd0;
    cyc(); #2;
    chk("flush_all_count", 64'(count), 0);
    chk("flush_all_ready", 64'(enq_ready), 1);

    // age compare across the ROB wrap
    enq(7'd66, 7'd1, 1'b1);
    enq(7'd62, 7'd2, 1'b1);
    #2;
    chk("wrap_idx", 64'(iss_idx), 1);
    chk("wrap_rob", 64'(iss_rob), 62);
    sb_q.push_back(mk(7'd62, 3'd1, 1'b0));
    sb_q.push_back(mk(7'd66, 3'd0, 1'b0));
    iss_ready = 1;
    cyc(); cyc();
    iss_ready = 0;
    redirect = 1; redirect_rob = 7'd62;
    cyc(); #2;
    chk("wrap_flush_count", 64'(count), 0);

    // delayed wakeup, then same-cycle wakeup at enqueue
    enq(7'd10, 7'd5, 1'b0);
    #2; chk("wk_wait0", 64'(iss_valid), 0);
    cyc(); #2; chk("wk_wait1", 64'(iss_valid), 0);
    cyc();
    wk_rd = '0; wk_rd[0 +: 7] = 7'd5; wk_rd[14 +: 7] = 7'd5; wk_en = 4'b0100;
    #2; chk("wk_same_cycle", 64'(iss_valid), 0);
    cyc(); #2;
    chk("wk_next_valid", 64'(iss_valid), 1);
    chk("wk_rs1", 64'(iss_rs1), 5);
    sb_q.push_back(mk(7'd10, 3'd0, 1'b0));
    iss_ready = 1; cyc(); iss_ready = 0;
    wk_rd = '0; wk_rd[7 +: 7] = 7'd9; wk_en = 4'b0010;
    enq(7'd11, 7'd9, 1'b0);
    #2;
    chk("wk_enq_valid", 64'(iss_valid), 1);
    chk("wk_enq_idx", 64'(iss_idx), 1);
    sb_q.push_back(mk(7'd11, 3'd1, 1'b0));
    iss_ready = 1; cyc(); iss_ready = 0;
    redirect = 1; redirect_rob = 7'd10;
    cyc(); #2;
    chk("wk_flush_count", 64'(count), 0);

    // fast replay back-off, TLB park with fault, slow replay
    enq(7'd20, 7'd20, 1'b1);
    sb_q.push_back(mk(7'd20, 3'd0, 1'b0));
    iss_ready = 1; cyc();
    rep_valid = 1; rep_idx = 3'd0; rep_reason = 2'd0;
    sb_q.push_back(mk(7'd20, 3'd0, 1'b0));
    cyc();
    for (int k = 1; k <= 3; k++) begin
      #2; chk($sformatf("backoff_T%0d", k), 64'(iss_valid), 0);
      cyc();
    end
    #2;
    chk("backoff_T4_valid", 64'(iss_valid), 1);
    cyc();
    rep_valid = 1; rep_idx = 3'd0; rep_reason = 2'd3;
    cyc(); #2;
    chk("tlb_park0", 64'(iss_valid), 0);
    cyc();
    tlb_wb_valid = 1; tlb_wb_idx = 3'd5; tlb_wb_exc = 1;
    cyc(); #2;
    chk("tlb_park_wrong_idx", 64'(iss_valid), 0);
    tlb_wb_valid = 1; tlb_wb_idx = 3'd0; tlb_wb_exc = 1;
    sb_q.push_back(mk(7'd20, 3'd0, 1'b1));
    cyc(); #2;
    chk("tlb_reissue_exc", 64'(iss_exc), 1);
    cyc();
    rep_valid = 1; rep_idx = 3'd0; rep_reason = 2'd1;
    sb_q.push_back(mk(7'd20, 3'd0, 1'b1));
    cyc(); #2;
    chk("slow_replay_valid", 64'(iss_valid), 1);
    cyc();
    iss_ready = 0; succ_valid = 1; succ_idx = 3'd0;
    cyc(); #2;
    chk("succ_count", 64'(count), 0);

    // redirect keeps only strictly older entries and blocks enqueue/issue
    enq(7'd4, 7'd1, 1'b1);
    enq(7'd6, 7'd1, 1'b1);
    enq(7'd9, 7'd1, 1'b1);
    #2; chk("redir_pre_count", 64'(count), 3);
    redirect = 1; redirect_rob = 7'd6;
    enq_valid = 1; enq_rob = 7'd12; enq_rs1v = 1; enq_payload = pl(7'd12);
    #1; chk("redir_iss_blocked", 64'(iss_valid), 0);
    cyc(); #2;
    chk("redir_count", 64'(count), 1);
    chk("redir_survivor", 64'(iss_rob), 4);
    enq(7'd6, 7'd1, 1'b1);
    enq(7'd9, 7'd1, 1'b1);
    redirect = 1; redirect_rob = 7'd6; succ_valid = 1; succ_idx = 3'd0;
    cyc(); #2;
    chk("redir_succ_count", 64'(count), 0);

    // full bank: a same-cycle free does not open a slot
    for (int i = 0; i < 8; i++) enq(7'(i), 7'(i), 1'b1);
    succ_valid = 1; succ_idx = 3'd3;
    enq_valid = 1; enq_rob = 7'd30; enq_rs1v = 1; enq_payload = pl(7'd30);
    #2; chk("full_enq_ready", 64'(enq_ready), 0);
    cyc(); #2;
    chk("full_after_free_count", 64'(count), 7);
    chk("full_after_free_ready", 64'(enq_ready), 1);
    enq(7'd30, 7'd3, 1'b1);
    #2; chk("full_refill_count", 64'(count), 8);
    for (int i = 0; i < 8; i++) if (i != 3) sb_q.push_back(mk(7'(i), 3'(i), 1'b0));
    sb_q.push_back(mk(7'd30, 3'd3, 1'b0));
    iss_ready = 1;
    repeat (8) cyc();
    iss_ready = 0;
    redirect = 1; redirect_rob = 7'd0;
    cyc(); #2;
    chk("full_flush_count", 64'(count), 0);

    // reset mid-operation overrides a concurrent enqueue
    enq(7'd3, 7'd1, 1'b1);
    enq(7'd4, 7'd1, 1'b1);
    rst = 1; enq_valid = 1; enq_rob = 7'd5;
    cyc();
    rst = 0; #2;
    chk("midrst_count", 64'(count), 0);
    chk("midrst_iss_valid", 64'(iss_valid), 0);

    chk("sb_drained", 64'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
